// File: rtl/stopwatch_counter.sv
// Stopwatch timebase: button sync/edge detect, run/pause/clear FSM,
// 1 ms prescaler and 4-digit BCD count D.DDD held at 9.999 on overflow.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] fourth,
  output logic [3:0] third,
  output logic [3:0] second,
  output logic [3:0] first,
  output logic       running,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [3:0]       d3_q, d2_q, d1_q, d0_q;
  logic [3:0]       d3_d, d2_d, d1_d, d0_d;

  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic cl_meta_q, cl_sync_q, cl_prev_q;
  logic ss_edge, cl_edge, tick, at_max;

  // Two-flop synchronisers plus previous-value flops for edge detect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_meta_q <= 1'b0;
      ss_sync_q <= 1'b0;
      ss_prev_q <= 1'b0;
      cl_meta_q <= 1'b0;
      cl_sync_q <= 1'b0;
      cl_prev_q <= 1'b0;
    end else begin
      ss_meta_q <= start_stop;
      ss_sync_q <= ss_meta_q;
      ss_prev_q <= ss_sync_q;
      cl_meta_q <= clear;
      cl_sync_q <= cl_meta_q;
      cl_prev_q <= cl_sync_q;
    end
  end

  assign ss_edge = ss_sync_q & ~ss_prev_q;
  assign cl_edge = cl_sync_q & ~cl_prev_q;
  assign tick    = (state_q == RUN) && (presc_q == LAST);
  assign at_max  = (d3_q == 4'd9) && (d2_q == 4'd9) &&
                   (d1_q == 4'd9) && (d0_q == 4'd9);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clear beats start_stop, overflow beats pause
  always_comb begin
    state_d = state_q;
    if (cl_edge) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (ss_edge) state_d = RUN;
        RUN: begin
          if (tick && at_max) state_d = DONE;
          else if (ss_edge)   state_d = PAUSE;
        end
        PAUSE: if (ss_edge) state_d = RUN;
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state register only
  always_comb begin
    running  = 1'b0;
    overflow = 1'b0;
    unique case (state_q)
      RUN:     running  = 1'b1;
      DONE:    overflow = 1'b1;
      default: ;
    endcase
  end

  // Prescaler: counts in RUN, holds in PAUSE, zero otherwise
  always_comb begin
    presc_d = '0;
    if (!cl_edge) begin
      unique case (state_q)
        RUN:     presc_d = tick ? '0 : presc_q + CNT_W'(1);
        PAUSE:   presc_d = presc_q;
        default: presc_d = '0;
      endcase
    end
  end

  // BCD increment with digit carry; saturates at 9.999
  always_comb begin
    d3_d = d3_q;
    d2_d = d2_q;
    d1_d = d1_q;
    d0_d = d0_q;
    if (cl_edge) begin
      d3_d = 4'd0;
      d2_d = 4'd0;
      d1_d = 4'd0;
      d0_d = 4'd0;
    end else if (tick && !at_max) begin
      if (d0_q != 4'd9) begin
        d0_d = d0_q + 4'd1;
      end else begin
        d0_d = 4'd0;
        if (d1_q != 4'd9) begin
          d1_d = d1_q + 4'd1;
        end else begin
          d1_d = 4'd0;
          if (d2_q != 4'd9) begin
            d2_d = d2_q + 4'd1;
          end else begin
            d2_d = 4'd0;
            d3_d = d3_q + 4'd1;
          end
        end
      end
    end
  end

  // Prescaler and digit registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      d3_q    <= 4'd0;
      d2_q    <= 4'd0;
      d1_q    <= 4'd0;
      d0_q    <= 4'd0;
    end else begin
      presc_q <= presc_d;
      d3_q    <= d3_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
    end
  end

  assign fourth = d3_q;
  assign third  = d2_q;
  assign second = d1_q;
  assign first  = d0_q;

endmodule
